// File: rtl/puf_challenge_sequencer_if.sv
// Bundle of the command, PUF-array and response signals around the challenge sequencer.
// The master modport is the sequencer's view; the slave modport is its environment's view.
interface puf_challenge_sequencer_if;
  // Host command side
  logic        start;
  logic        abort;
  logic [7:0]  base_challenge;
  logic [8:0]  num_challenges;
  logic [31:0] enable_mask;
  logic        busy;
  logic        seq_done;
  logic [7:0]  timeout_count;
  // PUF array side
  logic [7:0]  puf_challenge;
  logic [31:0] puf_enable;
  logic        puf_restart;
  logic        puf_all_done;
  logic [7:0]  puf_out;
  // Response link
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic [7:0]  resp_challenge;
  logic        resp_timeout;

  modport master (
    input  start, abort, base_challenge, num_challenges, enable_mask,
    input  puf_all_done, puf_out, resp_ready,
    output busy, seq_done, timeout_count,
    output puf_challenge, puf_enable, puf_restart,
    output resp_valid, resp_data, resp_challenge, resp_timeout
  );

  modport slave (
    output start, abort, base_challenge, num_challenges, enable_mask,
    output puf_all_done, puf_out, resp_ready,
    input  busy, seq_done, timeout_count,
    input  puf_challenge, puf_enable, puf_restart,
    input  resp_valid, resp_data, resp_challenge, resp_timeout
  );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// Steps the parallel PUF array through a run of challenges: clear, run until done or
// timeout, capture the response and hand it to the host link over valid/ready.
module puf_challenge_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock,
  input  logic                       computer_reset,
  puf_challenge_sequencer_if.master  seq_if
);

  localparam logic [15:0] SettleLast  = 16'(SETTLE_CYCLES);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StEmit, StDone} state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        seq_done_q, seq_done_d;
  logic [7:0]  timeout_count_q, timeout_count_d;
  logic [7:0]  puf_challenge_q, puf_challenge_d;
  logic [31:0] puf_enable_q, puf_enable_d;
  logic        puf_restart_q, puf_restart_d;
  logic        resp_valid_q, resp_valid_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic [7:0]  resp_challenge_q, resp_challenge_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic [31:0] mask_q, mask_d;
  logic [8:0]  remaining_q, remaining_d;
  // Shared by CLEAR (settle count) and RUN (timeout count); both start at 1 on entry.
  logic [15:0] cnt_q, cnt_d;

  // Next-state and registered-output computation; abort overrides everything outside IDLE.
  always_comb begin
    state_d          = state_q;
    busy_d           = busy_q;
    seq_done_d       = 1'b0;
    timeout_count_d  = timeout_count_q;
    puf_challenge_d  = puf_challenge_q;
    puf_enable_d     = puf_enable_q;
    puf_restart_d    = puf_restart_q;
    resp_valid_d     = resp_valid_q;
    resp_data_d      = resp_data_q;
    resp_challenge_d = resp_challenge_q;
    resp_timeout_d   = resp_timeout_q;
    mask_d           = mask_q;
    remaining_d      = remaining_q;
    cnt_d            = cnt_q;

    if (state_q != StIdle && seq_if.abort) begin
      state_d       = StIdle;
      busy_d        = 1'b0;
      resp_valid_d  = 1'b0;
      puf_enable_d  = '0;
      puf_restart_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seq_if.start) begin
            mask_d          = seq_if.enable_mask;
            remaining_d     = seq_if.num_challenges;
            puf_challenge_d = seq_if.base_challenge;
            busy_d          = 1'b1;
            timeout_count_d = '0;
            cnt_d           = 16'd1;
            if (seq_if.num_challenges == '0) begin
              state_d    = StDone;
              seq_done_d = 1'b1;
            end else begin
              state_d       = StClear;
              puf_restart_d = 1'b1;
            end
          end
        end
        StClear: begin
          if (cnt_q == SettleLast) begin
            state_d       = StRun;
            puf_restart_d = 1'b0;
            puf_enable_d  = mask_q;
            cnt_d         = 16'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StRun: begin
          if (seq_if.puf_all_done || cnt_q == TimeoutLast) begin
            state_d          = StEmit;
            puf_enable_d     = '0;
            resp_valid_d     = 1'b1;
            resp_data_d      = seq_if.puf_out;
            resp_challenge_d = puf_challenge_q;
            // Done wins over a coincident timeout.
            resp_timeout_d   = ~seq_if.puf_all_done;
            if (!seq_if.puf_all_done && timeout_count_q != 8'hFF) begin
              timeout_count_d = timeout_count_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StEmit: begin
          if (seq_if.resp_ready) begin
            resp_valid_d = 1'b0;
            remaining_d  = remaining_q - 9'd1;
            if (remaining_q == 9'd1) begin
              state_d    = StDone;
              seq_done_d = 1'b1;
            end else begin
              state_d         = StClear;
              puf_challenge_d = puf_challenge_q + 8'd1;
              puf_restart_d   = 1'b1;
              cnt_d           = 16'd1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge computer_reset) begin
    if (!computer_reset) begin
      state_q          <= StIdle;
      busy_q           <= 1'b0;
      seq_done_q       <= 1'b0;
      timeout_count_q  <= '0;
      puf_challenge_q  <= '0;
      puf_enable_q     <= '0;
      puf_restart_q    <= 1'b0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= '0;
      resp_challenge_q <= '0;
      resp_timeout_q   <= 1'b0;
      mask_q           <= '0;
      remaining_q      <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      seq_done_q       <= seq_done_d;
      timeout_count_q  <= timeout_count_d;
      puf_challenge_q  <= puf_challenge_d;
      puf_enable_q     <= puf_enable_d;
      puf_restart_q    <= puf_restart_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_challenge_q <= resp_challenge_d;
      resp_timeout_q   <= resp_timeout_d;
      mask_q           <= mask_d;
      remaining_q      <= remaining_d;
      cnt_q            <= cnt_d;
    end
  end

  assign seq_if.busy           = busy_q;
  assign seq_if.seq_done       = seq_done_q;
  assign seq_if.timeout_count  = timeout_count_q;
  assign seq_if.puf_challenge  = puf_challenge_q;
  assign seq_if.puf_enable     = puf_enable_q;
  assign seq_if.puf_restart    = puf_restart_q;
  assign seq_if.resp_valid     = resp_valid_q;
  assign seq_if.resp_data      = resp_data_q;
  assign seq_if.resp_challenge = resp_challenge_q;
  assign seq_if.resp_timeout   = resp_timeout_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for the PUF challenge sequencer.
module tb_puf_challenge_sequencer;

  localparam int unsigned Settle  = 4;
  localparam int unsigned Timeout = 16;

  logic clock = 1'b0;
  logic computer_reset;
  int   checks = 0;
  int   errors = 0;

  puf_challenge_sequencer_if seq_if ();

  puf_challenge_sequencer #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock         (clock),
    .computer_reset(computer_reset),
    .seq_if        (seq_if)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] base, input logic [8:0] num, input logic [31:0] mask);
    seq_if.start          = 1'b1;
    seq_if.base_challenge = base;
    seq_if.num_challenges = num;
    seq_if.enable_mask    = mask;
    step();
    seq_if.start = 1'b0;
  endtask

  // Entered just after the edge that put the DUT in CLEAR; returns with resp_valid expected high.
  task automatic clear_run(input string tag, input logic [7:0] exp_chal, input int exp_clr,
                           input logic [31:0] mask, input int done_cycle, input logic [7:0] data,
                           input int exp_run, input logic exp_to);
    int n;
    seq_if.puf_out = data;
    chk({tag, " chal"}, seq_if.puf_challenge, exp_chal);
    n = 0;
    while (seq_if.puf_restart === 1'b1 && seq_if.puf_enable === 32'h0 && n < 64) begin
      n++;
      step();
    end
    chk({tag, " clear_cycles"}, n, exp_clr);
    n = 0;
    while (seq_if.puf_enable === mask && n < 64) begin
      n++;
      seq_if.puf_all_done = (n == done_cycle);
      step();
    end
    seq_if.puf_all_done = 1'b0;
    chk({tag, " run_cycles"}, n, exp_run);
    chk({tag, " valid"}, seq_if.resp_valid, 1);
    chk({tag, " enable_emit"}, seq_if.puf_enable, 0);
    chk({tag, " data"}, seq_if.resp_data, data);
    chk({tag, " resp_chal"}, seq_if.resp_challenge, exp_chal);
    chk({tag, " timeout"}, seq_if.resp_timeout, exp_to);
  endtask

  task automatic emit(input string tag, input int stall, input logic [7:0] data);
    seq_if.resp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, " stall_valid"}, seq_if.resp_valid, 1);
      chk({tag, " stall_data"}, seq_if.resp_data, data);
      chk({tag, " stall_enable"}, seq_if.puf_enable, 0);
    end
    seq_if.resp_ready = 1'b1;
    step();
    seq_if.resp_ready = 1'b0;
    chk({tag, " valid_drop"}, seq_if.resp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c;
    computer_reset        = 1'b0;
    seq_if.start          = 1'b0;
    seq_if.abort          = 1'b0;
    seq_if.base_challenge = '0;
    seq_if.num_challenges = '0;
    seq_if.enable_mask    = '0;
    seq_if.puf_all_done   = 1'b0;
    seq_if.puf_out        = '0;
    seq_if.resp_ready     = 1'b0;
    #12;
    chk("rst busy", seq_if.busy, 0);
    chk("rst enable", seq_if.puf_enable, 0);
    chk("rst restart", seq_if.puf_restart, 0);
    chk("rst valid", seq_if.resp_valid, 0);
    chk("rst seq_done", seq_if.seq_done, 0);
    chk("rst tcount", seq_if.timeout_count, 0);
    computer_reset = 1'b1;
    step();

    // Single challenge
    do_start(8'h3C, 9'd1, 32'hFFFF_FFFF);
    chk("s1 busy", seq_if.busy, 1);
    clear_run("s1", 8'h3C, 4, 32'hFFFF_FFFF, 10, 8'hA5, 10, 1'b0);
    emit("s1", 0, 8'hA5);
    chk("s1 seq_done", seq_if.seq_done, 1);
    chk("s1 busy_done", seq_if.busy, 1);
    step();
    chk("s1 seq_done_once", seq_if.seq_done, 0);
    chk("s1 busy_fall", seq_if.busy, 0);

    // Wrap-around with back-pressure
    do_start(8'hFE, 9'd3, 32'h0F0F_0F0F);
    c = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      clear_run("s2", c, 4, 32'h0F0F_0F0F, 3, 8'h10 + 8'(k), 3, 1'b0);
      emit("s2", 5, 8'h10 + 8'(k));
      c = c + 8'd1;
    end
    chk("s2 seq_done", seq_if.seq_done, 1);
    step();

    // Timeouts, then done coincident with timeout
    do_start(8'h50, 9'd2, 32'h1);
    clear_run("s3a", 8'h50, 4, 32'h1, 0, 8'h77, 16, 1'b1);
    chk("s3a tcount", seq_if.timeout_count, 1);
    emit("s3a", 0, 8'h77);
    clear_run("s3b", 8'h51, 4, 32'h1, 0, 8'h78, 16, 1'b1);
    chk("s3b tcount", seq_if.timeout_count, 2);
    emit("s3b", 0, 8'h78);
    chk("s3 seq_done", seq_if.seq_done, 1);
    chk("s3 tcount_hold", seq_if.timeout_count, 2);
    step();
    do_start(8'h60, 9'd1, 32'h1);
    chk("s3c tcount_clr", seq_if.timeout_count, 0);
    clear_run("s3c", 8'h60, 4, 32'h1, 16, 8'h88, 16, 1'b0);
    chk("s3c tcount", seq_if.timeout_count, 0);
    emit("s3c", 0, 8'h88);
    chk("s3c seq_done", seq_if.seq_done, 1);
    step();

    // Zero count
    do_start(8'h33, 9'd0, 32'h1);
    chk("s4 seq_done", seq_if.seq_done, 1);
    chk("s4 valid", seq_if.resp_valid, 0);
    chk("s4 restart", seq_if.puf_restart, 0);
    chk("s4 busy", seq_if.busy, 1);
    step();
    chk("s4 busy_fall", seq_if.busy, 0);
    // Start while busy is ignored
    do_start(8'h20, 9'd1, 32'hFF);
    seq_if.start          = 1'b1;
    seq_if.base_challenge = 8'h11;
    seq_if.num_challenges = 9'd5;
    seq_if.enable_mask    = 32'h0;
    step();
    seq_if.start = 1'b0;
    clear_run("s4b", 8'h20, Settle - 1, 32'hFF, 2, 8'h44, 2, 1'b0);
    emit("s4b", 0, 8'h44);
    chk("s4b seq_done", seq_if.seq_done, 1);
    step();

    // Abort mid-EMIT
    do_start(8'h40, 9'd2, 32'h3);
    clear_run("s5a", 8'h40, 4, 32'h3, 1, 8'h55, 1, 1'b0);
    step();
    chk("s5a valid_hold", seq_if.resp_valid, 1);
    seq_if.abort = 1'b1;
    step();
    seq_if.abort = 1'b0;
    chk("s5a valid", seq_if.resp_valid, 0);
    chk("s5a enable", seq_if.puf_enable, 0);
    chk("s5a busy", seq_if.busy, 0);
    chk("s5a seq_done", seq_if.seq_done, 0);
    step();
    chk("s5a seq_done_later", seq_if.seq_done, 0);
    // Abort mid-RUN
    do_start(8'h70, 9'd3, 32'h3);
    repeat (Settle) step();
    chk("s5b enable_run", seq_if.puf_enable, 32'h3);
    seq_if.abort = 1'b1;
    step();
    seq_if.abort = 1'b0;
    chk("s5b enable", seq_if.puf_enable, 0);
    chk("s5b restart", seq_if.puf_restart, 0);
    chk("s5b busy", seq_if.busy, 0);
    step();
    chk("s5b seq_done", seq_if.seq_done, 0);
    do_start(8'h99, 9'd1, 32'hFFFF_0000);
    clear_run("s5c", 8'h99, 4, 32'hFFFF_0000, 5, 8'hC3, 5, 1'b0);
    emit("s5c", 2, 8'hC3);
    chk("s5c seq_done", seq_if.seq_done, 1);
    step();

    // Asynchronous reset during RUN
    do_start(8'h5A, 9'd2, 32'hFFFF_FFFF);
    repeat (Settle + 1) step();
    chk("s6 enable_run", seq_if.puf_enable, 32'hFFFF_FFFF);
    #2;
    computer_reset = 1'b0;
    #1;
    chk("s6 busy", seq_if.busy, 0);
    chk("s6 chal", seq_if.puf_challenge, 0);
    chk("s6 enable", seq_if.puf_enable, 0);
    chk("s6 restart", seq_if.puf_restart, 0);
    chk("s6 resp_data", seq_if.resp_data, 0);
    chk("s6 resp_chal", seq_if.resp_challenge, 0);
    computer_reset = 1'b1;
    step();
    do_start(8'h12, 9'd1, 32'h1);
    clear_run("s6b", 8'h12, 4, 32'h1, 4, 8'h6E, 4, 1'b0);
    emit("s6b", 0, 8'h6E);
    chk("s6b seq_done", seq_if.seq_done, 1);
    step();
    chk("s6b busy_fall", seq_if.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Control block that drives the 8-bit parallel PUF array through a run of challenges without host intervention. For each challenge it clears the array, enables the selected ring oscillators, waits for all subblocks to report done (or times out), captures the 8-bit response and hands it to the host-side link over a valid/ready handshake. It sits between the host command decoder and the parallel PUF array. It owns the array's `challenge`, `enable` and restart inputs.

## Interface
- `SETTLE_CYCLES`, 4: cycles `puf_restart` is held high, with enables low, before each challenge (1..255).
- `TIMEOUT_CYCLES`, 65535: maximum RUN cycles before a forced capture (1..65535).
- `clock` in 1: single system clock; every register is on its rising edge.
- `computer_reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Accepted only in IDLE.
- `abort` in 1: synchronous cancel. Effective in any non-IDLE state.
- `base_challenge` in 8: first challenge. Sampled when `start` is accepted.
- `num_challenges` in 9: number of challenges, 0..256. Sampled when `start` is accepted.
- `enable_mask` in 32: oscillator enable pattern applied during RUN. Sampled when `start` is accepted.
- `busy` out 1: high from the accept cycle until the return to IDLE.
- `puf_challenge` out 8: challenge bus to the array.
- `puf_enable` out 32: enable bus to the array. Zero outside RUN.
- `puf_restart` out 1: high in CLEAR. Integration maps it onto the array's reset.
- `puf_all_done` in 1: AND of the subblock done flags.
- `puf_out` in 8: array response.
- `resp_valid` out 1, `resp_ready` in 1: response handshake.
- `resp_data` out 8: captured response.
- `resp_challenge` out 8: challenge that produced `resp_data`.
- `resp_timeout` out 1: the response was force-captured on timeout.
- `seq_done` out 1: one-cycle pulse when a run completes normally.
- `timeout_count` out 8: saturating count of timeouts. Cleared on accepted `start`.

## Operation
- Reset values: every output is 0, and the state is IDLE.
- States: IDLE, CLEAR, RUN, EMIT, DONE.
- IDLE:
  - `start`=1 latches the inputs, sets remaining=`num_challenges`, sets `puf_challenge`=`base_challenge`, and sets `busy`=1.
  - If remaining=0, go to DONE; otherwise go to CLEAR.
- CLEAR:
  - `puf_restart`=1 and `puf_enable`=0 for exactly SETTLE_CYCLES cycles, then go to RUN.
  - `puf_all_done` is ignored in this state.
- RUN:
  - `puf_enable`=latched mask; the cycle counter increments each cycle.
  - On the first cycle with `puf_all_done`=1: register `puf_out` into `resp_data`, `puf_challenge` into `resp_challenge`, and set `resp_timeout`=0. Go to EMIT.
  - If the counter reaches TIMEOUT_CYCLES without done: capture the same way with `resp_timeout`=1, increment `timeout_count` (saturates at 255), and go to EMIT.
  - If done and timeout occur in the same cycle, done wins (`resp_timeout`=0).
- EMIT:
  - `resp_valid`=1, `puf_enable`=0, and all `resp_*` outputs are held stable until `resp_valid`&&`resp_ready`.
  - On transfer, decrement remaining. If remaining becomes 0, go to DONE. Otherwise set `puf_challenge`=`puf_challenge`+1 (mod 256, so 0xFF wraps to 0x00) and go to CLEAR.
- DONE: `seq_done`=1 for one cycle, then go to IDLE with `busy`=0.
- `abort`:
  - Next state is IDLE from any state.
  - `resp_valid`, `puf_enable` and `puf_restart` drop at that edge.
  - No `seq_done` pulse; a pending response is discarded.
  - `abort` has priority over `start`, done, timeout and handshake.
- `start` while `busy` is ignored and does not alter latched values.
- `computer_reset` asserted mid-run forces every output to its reset value immediately (asynchronous), with no handshake completion.

## Timing
- `start` sampled at edge k: `busy`=1 and `puf_restart`=1 from k+1 through k+SETTLE_CYCLES. RUN (`puf_enable`=mask) begins at k+SETTLE_CYCLES+1.
- `puf_all_done` sampled high at edge t: `resp_valid`=1 and `puf_enable`=0 from t+1.
- Timeout capture occurs at the edge where the RUN counter hits TIMEOUT_CYCLES, counting the first RUN cycle as 1.
- `resp_ready` already high when `resp_valid` rises gives a one-cycle EMIT. The next CLEAR starts the following cycle.
- Minimum per-challenge period is SETTLE_CYCLES+2 cycles, measured with done on the first RUN cycle and `resp_ready` held high.
- `seq_done` is one cycle after the last transfer; `busy` falls one cycle later.

## Test plan
- **Single challenge.** Reset, then `start` with base=0x3C, num=1, mask=0xFFFFFFFF, array done after 10 RUN cycles with `puf_out`=0xA5.
  - Expect one response: data=0xA5, challenge=0x3C, timeout=0.
  - Expect `seq_done` once and 4 CLEAR cycles before enable.
- **Wrap-around with back-pressure.** base=0xFE, num=3, `resp_ready` low for 5 cycles per response.
  - Expect challenges 0xFE, 0xFF, 0x00 in order.
  - `resp_data` stable while stalled; `puf_enable`=0 during stalls.
- **Timeout.** TIMEOUT_CYCLES=16, done never asserted, num=2.
  - Expect two responses with `resp_timeout`=1 and `timeout_count`=2.
  - Done and timeout on the same cycle must give `resp_timeout`=0.
- **Zero count and ignored start.** num=0: `seq_done` pulses with no `resp_valid`.
  - A second `start` with base=0x11 during a busy run leaves `puf_challenge` unchanged.
- **Abort mid-EMIT and mid-RUN.** Expect `resp_valid`/`puf_enable`=0 at the next edge, return to IDLE, and no `seq_done`.
  - A subsequent `start` runs normally.
- **Async reset during RUN.** All outputs go to 0 immediately.
  - After release, num=1 completes correctly.
